lsb_stego_embedder: RTL and testbench

Streaming, parametrised LSB steganography embedder. Replaces the per-byte, one-text-bit-per-channel instance array with a single pipelined engine. Accepts image channel bytes and message bytes on valid/ready streams, and embeds 1..LSB_BITS message bits (runtime-selectable) into each channel byte. After the message is exhausted it passes the remaining frame bytes through unchanged. Sits between the image-memory reader and the output-file/memory writer in the stego datapath.

---
 rtl/lsb_stego_embedder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lsb_stego_embedder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_stego_embedder.sv
// lsb_stego_embedder: streaming LSB steganography engine.
// Embeds 1..LSB_BITS message bits (runtime cfg_bpb) into the low bits of each
// channel byte, then passes the rest of the frame through unchanged.
// Optional macro STEGO_LEN_HEADER_EN: prepend cfg_msg_len (LEN_W bits,
// LSB-first) to the embedded bit stream.
module lsb_stego_embedder #(
    parameter int unsigned PIXEL_W  = 8,
    parameter int unsigned MSG_W    = 8,
    parameter int unsigned LSB_BITS = 4,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(LSB_BITS+1)-1:0] cfg_bpb,
    input  logic [LEN_W-1:0]              cfg_msg_len,
    input  logic [LEN_W-1:0]              cfg_frame_len,
    input  logic [PIXEL_W-1:0]            pix_in_data,
    input  logic                          pix_in_valid,
    output logic                          pix_in_ready,
    input  logic [MSG_W-1:0]              msg_data,
    input  logic                          msg_valid,
    output logic                          msg_ready,
    output logic [PIXEL_W-1:0]            pix_out_data,
    output logic                          pix_out_valid,
    input  logic                          pix_out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int unsigned BPB_W = $clog2(LSB_BITS + 1);
    localparam int unsigned BUF_W = MSG_W + LSB_BITS;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {StIdle, StEmbed, StPass} state_e;

    state_e             state_q, state_d;
    logic [BPB_W-1:0]   bpb_q, bpb_d;
    logic [LEN_W-1:0]   words_q, words_d;
    logic [LEN_W-1:0]   bytes_q, bytes_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIXEL_W-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;

    logic               embedding;
    logic               hdr_pending;
    logic               src_empty;
    logic               room;
    logic               msg_fire;
    logic               pix_fire;
    logic               app_fire;
    logic [MSG_W-1:0]   app_word;
    logic [CNT_W-1:0]   app_cnt;
    logic [CNT_W-1:0]   take;
    logic [PIXEL_W-1:0] emb_mask;
    logic [PIXEL_W-1:0] pix_emb;
    logic               bits_after;
    logic               drop;
    logic               start_has_bits;
    logic [BPB_W-1:0]   bpb_clamped;

`ifdef STEGO_LEN_HEADER_EN
    localparam int unsigned HCNT_W = $clog2(LEN_W + 1);

    logic [LEN_W-1:0]  hdr_q, hdr_d;
    logic [HCNT_W-1:0] hdr_left_q, hdr_left_d;
    logic [HCNT_W-1:0] hdr_take;
    logic              hdr_fire;

    assign hdr_pending    = (hdr_left_q != '0);
    assign start_has_bits = 1'b1;
    assign hdr_fire       = embedding && (bytes_q != '0) && hdr_pending && room;

    // Header chunk size: a full message word, or whatever header bits remain.
    always_comb begin
        hdr_take = hdr_left_q;
        if (32'(hdr_left_q) >= MSG_W) begin
            hdr_take = HCNT_W'(MSG_W);
        end
    end

    // Header shift register: loaded on start, drained in word-sized chunks.
    always_comb begin
        hdr_d      = hdr_q;
        hdr_left_d = hdr_left_q;
        if (state_q == StIdle) begin
            if (start && (cfg_frame_len != '0)) begin
                hdr_d      = cfg_msg_len;
                hdr_left_d = HCNT_W'(LEN_W);
            end
        end else if (drop) begin
            hdr_left_d = '0;
        end else if (hdr_fire) begin
            hdr_d      = hdr_q >> MSG_W;
            hdr_left_d = hdr_left_q - hdr_take;
        end
    end

    // Header state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_q      <= '0;
            hdr_left_q <= '0;
        end else begin
            hdr_q      <= hdr_d;
            hdr_left_q <= hdr_left_d;
        end
    end
`else
    assign hdr_pending    = 1'b0;
    assign start_has_bits = (cfg_msg_len != '0);
`endif

    assign embedding = (state_q == StEmbed);
    assign src_empty = (words_q == '0) && !hdr_pending;
    assign room      = (cnt_q < CNT_W'(bpb_q));

    assign msg_ready    = embedding && (bytes_q != '0) && !hdr_pending &&
                          (words_q != '0) && room;
    assign pix_in_ready = (!out_valid_q || pix_out_ready) && (state_q != StIdle) &&
                          (bytes_q != '0) &&
                          ((state_q == StPass) || !room || src_empty);

    assign msg_fire = msg_valid && msg_ready;
    assign pix_fire = pix_in_valid && pix_in_ready;

    assign bpb_clamped = ((cfg_bpb == '0) || (cfg_bpb > BPB_W'(LSB_BITS))) ?
                         BPB_W'(1) : cfg_bpb;

    // Select what enters the bit buffer this cycle (header chunk or message word).
    always_comb begin
`ifdef STEGO_LEN_HEADER_EN
        app_fire = msg_fire || hdr_fire;
        app_word = hdr_pending ? MSG_W'(hdr_q) : msg_data;
        app_cnt  = hdr_pending ? CNT_W'(hdr_take) : CNT_W'(MSG_W);
`else
        app_fire = msg_fire;
        app_word = msg_data;
        app_cnt  = CNT_W'(MSG_W);
`endif
    end

    // Embed datapath: replace the low 'take' bits; take < bpb only for the final partial.
    always_comb begin
        take = '0;
        if (embedding) begin
            take = room ? cnt_q : CNT_W'(bpb_q);
        end
        emb_mask   = ~({PIXEL_W{1'b1}} << take);
        pix_emb    = (pix_in_data & ~emb_mask) |
                     (PIXEL_W'(buf_q[LSB_BITS-1:0]) & emb_mask);
        bits_after = ((cnt_q - take) != '0) || !src_empty;
    end

    // Next-state logic for control, counters, bit buffer and output register.
    always_comb begin
        state_d     = state_q;
        bpb_d       = bpb_q;
        words_d     = words_q;
        bytes_d     = bytes_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        drop        = 1'b0;

        if (out_valid_q && pix_out_ready) begin
            out_valid_d = 1'b0;
        end
        if (pix_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = pix_emb;
        end

        if (state_q == StIdle) begin
            if (start) begin
                bpb_d      = bpb_clamped;
                words_d    = cfg_msg_len;
                bytes_d    = cfg_frame_len;
                buf_d      = '0;
                cnt_d      = '0;
                overflow_d = 1'b0;
                if (cfg_frame_len == '0) begin
                    // Nothing to carry the message: finish at once.
                    done_d     = 1'b1;
                    overflow_d = start_has_bits;
                end else begin
                    state_d = start_has_bits ? StEmbed : StPass;
                end
            end
        end else begin
            if (app_fire) begin
                buf_d = buf_q | (BUF_W'(app_word) << cnt_q);
                cnt_d = cnt_q + app_cnt;
                if (msg_fire) begin
                    words_d = words_q - LEN_W'(1);
                end
            end
            if (pix_fire) begin
                bytes_d = bytes_q - LEN_W'(1);
                buf_d   = buf_q >> take;
                cnt_d   = cnt_q - take;
                if (embedding && !bits_after) begin
                    state_d = StPass;
                end
                if ((bytes_q == LEN_W'(1)) && bits_after) begin
                    // Frame exhausted with message left: discard the remainder.
                    overflow_d = 1'b1;
                    drop       = 1'b1;
                    words_d    = '0;
                    buf_d      = '0;
                    cnt_d      = '0;
                end
            end
            if ((bytes_q == '0) && (!out_valid_q || pix_out_ready)) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bpb_q       <= '0;
            words_q     <= '0;
            bytes_q     <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bpb_q       <= bpb_d;
            words_q     <= words_d;
            bytes_q     <= bytes_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pix_out_data  = out_data_q;
    assign pix_out_valid = out_valid_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_lsb_stego_embedder.sv
// Self-checking bench for lsb_stego_embedder: bit-stream reference model,
// randomized handshakes and backpressure, plus literal frame expectations.
module tb_lsb_stego_embedder;

    localparam int PW = 8;
    localparam int MW = 8;
    localparam int LB = 4;
    localparam int LW = 16;
    localparam int BW = $clog2(LB + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BW-1:0] cfg_bpb;
    logic [LW-1:0] cfg_msg_len;
    logic [LW-1:0] cfg_frame_len;
    logic [PW-1:0] pix_in_data;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic [MW-1:0] msg_data;
    logic          msg_valid;
    logic          msg_ready;
    logic [PW-1:0] pix_out_data;
    logic          pix_out_valid;
    logic          pix_out_ready;
    logic          busy;
    logic          done;
    logic          overflow;

    lsb_stego_embedder #(
        .PIXEL_W (PW),
        .MSG_W   (MW),
        .LSB_BITS(LB),
        .LEN_W   (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_bpb      (cfg_bpb),
        .cfg_msg_len  (cfg_msg_len),
        .cfg_frame_len(cfg_frame_len),
        .pix_in_data  (pix_in_data),
        .pix_in_valid (pix_in_valid),
        .pix_in_ready (pix_in_ready),
        .msg_data     (msg_data),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .pix_out_data (pix_out_data),
        .pix_out_valid(pix_out_valid),
        .pix_out_ready(pix_out_ready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            done_cnt = 0;
    int            both_cnt = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];
    logic [7:0]    msg_a[$];
    logic [7:0]    pix_a[$];
    bit            exp_ovf;
    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference model: build the embedded bit stream, then fill each byte in turn.
    task automatic model_frame(input int cfg_b);
        bit         bits[$];
        int         bpb_eff;
        int         k;
        logic [7:0] b;
        bpb_eff = (cfg_b == 0 || cfg_b > LB) ? 1 : cfg_b;
        exp_q.delete();
`ifdef STEGO_LEN_HEADER_EN
        for (int i = 0; i < LW; i++) bits.push_back(((msg_a.size() >> i) & 1) != 0);
`endif
        foreach (msg_a[w]) for (int i = 0; i < MW; i++) bits.push_back(msg_a[w][i]);
        foreach (pix_a[p]) begin
            b = pix_a[p];
            k = (bits.size() < bpb_eff) ? bits.size() : bpb_eff;
            for (int i = 0; i < k; i++) b[i] = bits.pop_front();
            exp_q.push_back(b);
        end
        exp_ovf = (bits.size() != 0);
    endtask

    // Output monitor: every transfer against the model, and stability under stall.
    always begin
        @(negedge clk);
        #3;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {pix_out_valid, pix_out_data}, {1'b1, prev_data});
            end
            if (pix_out_valid && pix_out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_extra: got %0h, expected no output", pix_out_data);
                end else if (pix_out_data !== exp_q[0]) begin
                    fails++;
                    $display("FAIL out_data: got %0h, expected %0h", pix_out_data, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got_q.push_back(pix_out_data);
            end
            if (done) done_cnt++;
            if (msg_valid && msg_ready && pix_in_valid && pix_in_ready) both_cnt++;
            prev_stall = pix_out_valid && !pix_out_ready;
            prev_data  = pix_out_data;
        end
    end

    task automatic run_frame(input int cfg_b, input int stall_pct, input int gap_pct,
                             input int abort_at, input int poke_at);
        int pi = 0;
        int mi = 0;
        int cyc = 0;
        int d0;
        int b0;
        bit seen = 1'b0;
        bit pfire = 1'b0;
        bit mfire = 1'b0;
        model_frame(cfg_b);
        got_q.delete();
        d0 = done_cnt;
        b0 = both_cnt;
        @(negedge clk);
        start         = 1'b1;
        cfg_bpb       = BW'(cfg_b);
        cfg_msg_len   = LW'(msg_a.size());
        cfg_frame_len = LW'(pix_a.size());
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_at);
            if (start) begin
                cfg_bpb       = BW'($urandom_range(LB));
                cfg_msg_len   = LW'($urandom_range(3));
                cfg_frame_len = LW'($urandom_range(3));
            end
            if (abort_at != 0 && cyc == abort_at) begin
                check("abort_busy", busy, 1'b1);
                reset = 1'b1;
                #1;
                check("abort_outputs_zero",
                      {pix_in_ready, msg_ready, pix_out_valid, pix_out_data, busy, done, overflow},
                      '0);
                pix_in_valid = 1'b0;
                msg_valid    = 1'b0;
                exp_q.delete();
                @(negedge clk);
                reset = 1'b0;
                repeat (5) @(negedge clk);
                check("abort_no_done", done_cnt - d0, 0);
                return;
            end
            pix_out_ready = ($urandom_range(99) >= stall_pct);
            if (pfire) pix_in_valid = 1'b0;
            if (!pix_in_valid && pi < pix_a.size() && $urandom_range(99) >= gap_pct) begin
                pix_in_valid = 1'b1;
                pix_in_data  = pix_a[pi];
            end
            if (mfire) msg_valid = 1'b0;
            if (!msg_valid && mi < msg_a.size() && $urandom_range(99) >= gap_pct) begin
                msg_valid = 1'b1;
                msg_data  = msg_a[mi];
            end
            #3;
            pfire = pix_in_valid && pix_in_ready;
            mfire = msg_valid && msg_ready;
            if (pfire) pi++;
            if (mfire) mi++;
            if (done) seen = 1'b1;
        end
        pix_in_valid  = 1'b0;
        msg_valid     = 1'b0;
        pix_out_ready = 1'b1;
        start         = 1'b0;
        check("done_seen", seen, 1'b1);
        repeat (3) @(negedge clk);
        #3;
        check("done_once", done_cnt - d0, 1);
        check("idle_after", busy, 1'b0);
        check("overflow", overflow, exp_ovf);
        check("outputs_drained", exp_q.size(), 0);
        check("pixels_consumed", pi, pix_a.size());
        check("no_dual_accept", both_cnt - b0, 0);
        if (!exp_ovf) check("words_consumed", mi, msg_a.size());
    endtask

    task automatic fill(input int n_msg, input int n_pix, input int pix_mode, input int pv);
        msg_a.delete();
        pix_a.delete();
        for (int i = 0; i < n_msg; i++) msg_a.push_back(8'($urandom));
        for (int i = 0; i < n_pix; i++) pix_a.push_back(pix_mode != 0 ? 8'(pv) : 8'($urandom));
    endtask

    task automatic check_got(input string name, input int idx, input logic [7:0] want);
        check(name, (idx < got_q.size()) ? 32'(got_q[idx]) : 32'hDEAD, 32'(want));
    endtask

    initial begin
        logic [7:0] t1[10];
        logic [7:0] t2[4];
        logic [7:0] t6[6];
        t1 = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        t2 = '{8'h07, 8'h07, 8'h03, 8'h00};
        t6 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h03};

        reset = 1'b1; start = 1'b0; cfg_bpb = '0; cfg_msg_len = '0; cfg_frame_len = '0;
        pix_in_data = '0; pix_in_valid = 1'b0; msg_data = '0; msg_valid = 1'b0;
        pix_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("reset_busy", busy, 1'b0);
        check("reset_out_valid", pix_out_valid, 1'b0);
        check("reset_out_data", pix_out_data, '0);
        check("reset_done_ovf", {done, overflow}, 2'b00);
        check("reset_readies", {pix_in_ready, msg_ready}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        pix_out_ready = 1'b1;

`ifndef STEGO_LEN_HEADER_EN
        fill(0, 10, 1, 8'hFF);
        msg_a.push_back(8'hA5);
        run_frame(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) check_got("t1_byte", i, t1[i]);

        fill(0, 4, 1, 8'h00);
        msg_a.push_back(8'hFF);
        run_frame(3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) check_got("t2_byte", i, t2[i]);

        fill(2, 8, 0, 0);
        run_frame(1, 20, 20, 0, 0);
        check("t4_overflow_literal", overflow, 1'b1);
`else
        fill(0, 6, 1, 8'h00);
        msg_a.push_back(8'h3C);
        run_frame(4, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) check_got("t6_byte", i, t6[i]);
`endif

        // Heavy backpressure, bpb=2, 64-byte frame, 8 words.
        fill(8, 64, 0, 0);
        run_frame(2, 50, 20, 0, 0);

        // Reset mid-embed, then a clean frame with a start poked while busy.
        fill(4, 40, 0, 0);
        run_frame(1, 10, 0, 6, 0);
        fill(3, 20, 0, 0);
        run_frame(3, 30, 10, 0, 4);

        // Boundaries: empty frame, pass-through only, clamped bpb values.
        fill(0, 0, 0, 0);
        run_frame(2, 0, 0, 0, 0);
        fill(0, 12, 0, 0);
        run_frame(4, 25, 25, 0, 0);
        fill(2, 20, 0, 0);
        run_frame(0, 0, 0, 0, 0);
        fill(2, 10, 0, 0);
        run_frame(7, 10, 10, 0, 0);

        for (int r = 0; r < 12; r++) begin
            fill($urandom_range(6), $urandom_range(40), 0, 0);
            run_frame($urandom_range(7), $urandom_range(60), $urandom_range(40), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
